sram_resp_confreg: RTL and testbench
====================================

Name: sram_resp_confreg

Overview:
- Responder for the CPU's two SRAM-style ports (inst_sram_*, data_sram_*); sits on the SoC side of the core top.
- Provides a dual-port word memory (instruction read port, data read/write port) plus a small memory-mapped config register block (LED, switch, display number, timer) decoded on the data port.
- Fixed one-cycle read latency, matching the core's pipeline expectation.

Parameters:
- MEM_AW, 14, memory word-address width (2^MEM_AW words of 32 bits).
- CONF_BASE, 32'h1FAF_0000, physical base of the config region (64 KB window, match on addr[31:16]).
- TIMER_STEP, 1, increment added to the timer each cycle.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_sram_en  in  1  instruction read request
- inst_sram_wen  in  4  byte write enables (ignored; must be 0)
- inst_sram_addr  in  32  physical byte address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  instruction data, valid the cycle after en
- data_sram_en  in  1  data access request
- data_sram_wen  in  4  byte write enables, bit i -> wdata[8i+7:8i]
- data_sram_addr  in  32  physical byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid the cycle after en
- switch_in  in  8  board switches
- led_out  out  16  LED register
- num_out  out  32  seven-segment number register

Behaviour:
- Clock: clk. Reset: resetn, asynchronous, active-low.
- Reset values: inst_sram_rdata=0, data_sram_rdata=0, led_out=16'hFFFF, num_out=0, timer=0. Memory array contents are not reset.
- Address decode:
  - data port is conf when data_sram_addr[31:16]==CONF_BASE[31:16]; otherwise memory.
  - memory word index = addr[MEM_AW+1:2]; higher bits ignored, so memory mirrors.
  - addr[1:0] ignored on both ports.
- Instruction port:
  - en=1 at edge N -> inst_sram_rdata = mem[idx] after edge N.
  - en=0 -> rdata holds its previous value.
  - inst_sram_wen is never applied.
- Data port, memory:
  - en=1, wen=0 -> read, data valid after the edge.
  - en=1, wen!=0 -> byte-merged write at the edge; data_sram_rdata holds.
  - en=0 -> no access, rdata holds.
- Data port, conf offsets (addr[15:0]):
  - 16'hF000 LED: rw, low 16 bits, byte-masked.
  - 16'hF010 NUM: rw, byte-masked.
  - 16'hF020 SWITCH: ro, read returns {24'b0, switch_in} sampled at the request edge.
  - 16'hE000 TIMER: rw, byte-masked.
  - Other offsets: read 0, write ignored.
  - Conf reads also have one-cycle latency.
- Timer: timer <= timer + TIMER_STEP every cycle. A data write to TIMER in the same cycle wins; there is no increment that cycle.
- Same-word conflict: data write and instruction read to the same word in the same cycle -> inst_sram_rdata returns the OLD word (read-before-write). The new value is visible on the next read.
- Reset asserted mid-access: outputs go to reset values immediately. A write whose edge coincides with reset assertion is not guaranteed; memory contents are otherwise retained.
- No backpressure, no error response; every request completes in one cycle.

Decomposition:
- Shared package: conf offset constants (LED_OFF, NUM_OFF, SWITCH_OFF, TIMER_OFF), CONF_BASE default, reset constants for LED and NUM.
- Sub-module dp_word_ram: 2^MEM_AW x 32, one read-only port, one read/write port with 4-bit byte enables, read-before-write, registered read data, no reset on the array.
- The top level holds decode, conf registers, timer and the read-data mux, including a registered select of memory vs conf.

Test Plan:
- Reset then idle: resetn=0 -> inst_rdata=0, data_rdata=0, led_out=16'hFFFF, num_out=0. After release, TIMER read after 10 idle cycles returns 10±1 per latency.
- Byte write then read: write 32'hDEADBEEF wen=4'hF at 0x0000_0100, then wen=4'b0010 wdata=32'h0000_5500 -> read next cycle returns 32'hDEAD55EF. Inst port at 0x100 returns the same.
- Conflict: in one cycle, data write 32'h1234_5678 and inst read at 0x200 (old 32'hAAAA_AAAA) -> inst_rdata=32'hAAAA_AAAA; next inst read returns 32'h1234_5678.
- Conf access: write 32'h0000_00A5 to 0x1FAF_F000 -> led_out=16'h00A5. switch_in=8'h3C, read 0x1FAF_F020 -> data_rdata=32'h3C. Read 0x1FAF_F004 -> 0.
- Timer override: write 32'h0000_1000 to TIMER in the same cycle as an increment -> next-cycle timer=32'h1000, following cycle 32'h1001.
- Mirroring and reset mid-stream: MEM_AW=14, write at 0x0001_0004 -> read at 0x0000_0004 returns the same word. Assert resetn during a read -> data_rdata=0 asynchronously; memory word still readable after release.

Source files
------------

// File: rtl/sram_resp_confreg_pkg.sv
// Shared constants, config-register select type and byte-merge helper for sram_resp_confreg.
package sram_resp_confreg_pkg;

    localparam logic [31:0] CONF_BASE_DEFAULT = 32'h1FAF_0000;

    localparam logic [15:0] LED_OFF    = 16'hF000;
    localparam logic [15:0] NUM_OFF    = 16'hF010;
    localparam logic [15:0] SWITCH_OFF = 16'hF020;
    localparam logic [15:0] TIMER_OFF  = 16'hE000;

    localparam logic [15:0] LED_RESET = 16'hFFFF;
    localparam logic [31:0] NUM_RESET = 32'h0000_0000;

    typedef enum logic [2:0] {
        CONF_NONE,
        CONF_LED,
        CONF_NUM,
        CONF_SWITCH,
        CONF_TIMER
    } conf_sel_e;

    // Replace only the bytes whose enable bit is set; bit i selects byte [8i+7:8i].
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_resp_confreg_dp_word_ram.sv
// Dual-port 32-bit word RAM: port A read-only, port B read/write with byte enables.
// Reads are registered and see the word as it was before any same-edge write.
module dp_word_ram
    import sram_resp_confreg_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          a_en,
    input  logic [AW-1:0] a_addr,
    output logic [31:0]   a_rdata,
    input  logic          b_en,
    input  logic [3:0]    b_wen,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-merged write on port B; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (b_en && (b_wen != 4'b0000)) begin
            mem[b_addr] <= byte_merge(mem[b_addr], b_wdata, b_wen);
        end
    end

    // Port A read register, holds its value while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_rdata <= '0;
        end else if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    // Port B read register, updated only on read accesses so it holds across writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_rdata <= '0;
        end else if (b_en && (b_wen == 4'b0000)) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sram_resp_confreg.sv
// SRAM-style responder: word memory on both CPU ports plus LED/NUM/SWITCH/TIMER
// registers decoded in the config window of the data port, all with one-cycle read latency.
module sram_resp_confreg
    import sram_resp_confreg_pkg::*;
#(
    parameter int          MEM_AW     = 14,
    parameter logic [31:0] CONF_BASE  = CONF_BASE_DEFAULT,
    parameter logic [31:0] TIMER_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    logic        data_is_conf;
    logic [15:0] conf_off;
    conf_sel_e   conf_sel;
    logic        data_rd;
    logic        conf_wr;
    logic        mem_b_en;
    logic [31:0] mem_data_rdata;
    logic [31:0] conf_rdata;
    logic [31:0] conf_rdata_q;
    logic        rd_conf_q;
    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] timer_q;
    logic [31:0] led_merged;
    logic        unused_bits;

    assign data_is_conf = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign conf_off     = data_sram_addr[15:0];
    assign data_rd      = data_sram_en && (data_sram_wen == 4'b0000);
    assign conf_wr      = data_sram_en && data_is_conf && (data_sram_wen != 4'b0000);
    assign mem_b_en     = data_sram_en && !data_is_conf;
    assign led_merged   = byte_merge({16'h0000, led_q}, data_sram_wdata, data_sram_wen);

    // Instruction-port write controls, address alignment bits and the LED merge's upper half carry no meaning.
    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr, data_sram_addr, led_merged[31:16]};

    dp_word_ram #(.AW(MEM_AW)) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .a_en    (inst_sram_en),
        .a_addr  (inst_sram_addr[MEM_AW+1:2]),
        .a_rdata (inst_sram_rdata),
        .b_en    (mem_b_en),
        .b_wen   (data_sram_wen),
        .b_addr  (data_sram_addr[MEM_AW+1:2]),
        .b_wdata (data_sram_wdata),
        .b_rdata (mem_data_rdata)
    );

    // Map the config-window offset onto one of the registers.
    always_comb begin
        conf_sel = CONF_NONE;
        case (conf_off)
            LED_OFF:    conf_sel = CONF_LED;
            NUM_OFF:    conf_sel = CONF_NUM;
            SWITCH_OFF: conf_sel = CONF_SWITCH;
            TIMER_OFF:  conf_sel = CONF_TIMER;
            default:    conf_sel = CONF_NONE;
        endcase
    end

    // Current value of the selected config register; unmapped offsets read as zero.
    always_comb begin
        conf_rdata = '0;
        case (conf_sel)
            CONF_LED:    conf_rdata = {16'h0000, led_q};
            CONF_NUM:    conf_rdata = num_q;
            CONF_SWITCH: conf_rdata = {24'h000000, switch_in};
            CONF_TIMER:  conf_rdata = timer_q;
            default:     conf_rdata = '0;
        endcase
    end

    // LED and NUM registers, byte-masked writes from the data port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q <= LED_RESET;
            num_q <= NUM_RESET;
        end else if (conf_wr) begin
            if (conf_sel == CONF_LED) begin
                led_q <= led_merged[15:0];
            end
            if (conf_sel == CONF_NUM) begin
                num_q <= byte_merge(num_q, data_sram_wdata, data_sram_wen);
            end
        end
    end

    // Free-running timer; a write in the same cycle replaces that cycle's increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else if (conf_wr && (conf_sel == CONF_TIMER)) begin
            timer_q <= byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        end else begin
            timer_q <= timer_q + TIMER_STEP;
        end
    end

    // Capture config read data and remember whether the last read targeted memory or config.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_conf_q    <= 1'b0;
            conf_rdata_q <= '0;
        end else if (data_rd) begin
            rd_conf_q    <= data_is_conf;
            conf_rdata_q <= conf_rdata;
        end
    end

    assign data_sram_rdata = rd_conf_q ? conf_rdata_q : mem_data_rdata;
    assign led_out         = led_q;
    assign num_out         = num_q;

endmodule

// File: tb/tb_sram_resp_confreg.sv
// Self-checking bench for sram_resp_confreg: a transaction-level model checked every
// cycle, plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_sram_resp_confreg;

    localparam int MEM_WORDS = 1 << 14;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    int tests_run    = 0;
    int tests_failed = 0;

    sram_resp_confreg dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .num_out         (num_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [31:0] m_inst, m_data, m_num, m_timer, m_old_timer, m_tmp;
    logic [15:0] m_led;
    bit          m_inst_ok, m_data_ok, m_timer_written;
    int          m_iw, m_dw;

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) & (MEM_WORDS - 1));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Model update: what each port must present after every clock edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_inst = 0; m_data = 0; m_inst_ok = 1; m_data_ok = 1;
            m_led = 16'hFFFF; m_num = 0; m_timer = 0;
        end else begin
            m_old_timer = m_timer;
            m_timer_written = 0;
            if (inst_sram_en) begin
                m_iw = widx(inst_sram_addr);
                m_inst_ok = m_mem.exists(m_iw);
                if (m_inst_ok) m_inst = m_mem[m_iw];
            end
            if (data_sram_en) begin
                if (data_sram_addr[31:16] == 16'h1FAF) begin
                    if (data_sram_wen == 4'h0) begin
                        m_data_ok = 1;
                        case (data_sram_addr[15:0])
                            16'hF000: m_data = {16'h0, m_led};
                            16'hF010: m_data = m_num;
                            16'hF020: m_data = {24'h0, switch_in};
                            16'hE000: m_data = m_old_timer;
                            default:  m_data = 0;
                        endcase
                    end else begin
                        case (data_sram_addr[15:0])
                            16'hF000: begin
                                m_tmp = merge({16'h0, m_led}, data_sram_wdata, data_sram_wen);
                                m_led = m_tmp[15:0];
                            end
                            16'hF010: m_num = merge(m_num, data_sram_wdata, data_sram_wen);
                            16'hE000: begin
                                m_timer = merge(m_timer, data_sram_wdata, data_sram_wen);
                                m_timer_written = 1;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    m_dw = widx(data_sram_addr);
                    if (data_sram_wen == 4'h0) begin
                        m_data_ok = m_mem.exists(m_dw);
                        if (m_data_ok) m_data = m_mem[m_dw];
                    end else if (m_mem.exists(m_dw)) begin
                        m_mem[m_dw] = merge(m_mem[m_dw], data_sram_wdata, data_sram_wen);
                    end else if (data_sram_wen == 4'hF) begin
                        m_mem[m_dw] = data_sram_wdata;
                    end
                end
            end
            if (!m_timer_written) m_timer = m_timer + 1;
        end
    end

    // Per-cycle comparison of every meaningful DUT output against the model.
    always @(negedge clk) begin
        if (m_inst_ok) begin
            tests_run++;
            if (inst_sram_rdata !== m_inst) begin
                tests_failed++;
                $display("[TB] FAIL model_inst t=%0t got %h want %h", $time, inst_sram_rdata, m_inst);
            end
        end
        if (m_data_ok) begin
            tests_run++;
            if (data_sram_rdata !== m_data) begin
                tests_failed++;
                $display("[TB] FAIL model_data t=%0t got %h want %h", $time, data_sram_rdata, m_data);
            end
        end
        tests_run++;
        if (led_out !== m_led) begin
            tests_failed++;
            $display("[TB] FAIL model_led t=%0t got %h want %h", $time, led_out, m_led);
        end
        tests_run++;
        if (num_out !== m_num) begin
            tests_failed++;
            $display("[TB] FAIL model_num t=%0t got %h want %h", $time, num_out, m_num);
        end
    end

    // Drive one cycle of requests (called at a falling edge), then return the ports to idle.
    task automatic applyStimulus(input logic ie, input logic [31:0] ia,
                                 input logic de, input logic [3:0] dw,
                                 input logic [31:0] da, input logic [31:0] dd);
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        data_sram_en    = de;
        data_sram_wen   = dw;
        data_sram_addr  = da;
        data_sram_wdata = dd;
        @(negedge clk);
        inst_sram_en  = 1'b0;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
    endtask

    // Compare an observed value with a hand-computed one.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        inst_sram_en    = 1'b0;
        inst_sram_wen   = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        switch_in       = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_inst", inst_sram_rdata, 32'h0);
        checkOutput("reset_data", data_sram_rdata, 32'h0);
        checkOutput("reset_led", {16'h0, led_out}, 32'h0000_FFFF);
        checkOutput("reset_num", num_out, 32'h0);

        // Release, idle ten cycles, then read the timer.
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(0, 0, 1, 4'h0, 32'h1FAF_E000, 0);
        tests_run++;
        if (data_sram_rdata < 32'd9 || data_sram_rdata > 32'd11) begin
            tests_failed++;
            $display("[TB] FAIL timer_idle got %0d want 10+-1", data_sram_rdata);
        end

        // Byte write then read on both ports.
        applyStimulus(0, 0, 1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 1, 4'b0010, 32'h0000_0100, 32'h0000_5500);
        applyStimulus(1, 32'h0000_0100, 1, 4'h0, 32'h0000_0100, 0);
        checkOutput("byte_merge_data", data_sram_rdata, 32'hDEAD_55EF);
        checkOutput("byte_merge_inst", inst_sram_rdata, 32'hDEAD_55EF);
        applyStimulus(0, 0, 1, 4'hF, 32'h0000_0104, 32'h1111_2222);
        checkOutput("data_hold_on_write", data_sram_rdata, 32'hDEAD_55EF);

        // Same-word write and instruction read: read sees the old word.
        applyStimulus(0, 0, 1, 4'hF, 32'h0000_0200, 32'hAAAA_AAAA);
        applyStimulus(1, 32'h0000_0200, 1, 4'hF, 32'h0000_0200, 32'h1234_5678);
        checkOutput("conflict_old", inst_sram_rdata, 32'hAAAA_AAAA);
        applyStimulus(1, 32'h0000_0202, 0, 4'h0, 0, 0);
        checkOutput("conflict_new", inst_sram_rdata, 32'h1234_5678);
        applyStimulus(0, 0, 0, 4'h0, 0, 0);
        checkOutput("inst_hold_idle", inst_sram_rdata, 32'h1234_5678);

        // Config register accesses.
        applyStimulus(0, 0, 1, 4'hF, 32'h1FAF_F000, 32'h0000_00A5);
        checkOutput("led_write", {16'h0, led_out}, 32'h0000_00A5);
        switch_in = 8'h3C;
        applyStimulus(0, 0, 1, 4'h0, 32'h1FAF_F020, 0);
        checkOutput("switch_read", data_sram_rdata, 32'h0000_003C);
        applyStimulus(0, 0, 1, 4'h0, 32'h1FAF_F004, 0);
        checkOutput("unmapped_read", data_sram_rdata, 32'h0);
        applyStimulus(0, 0, 1, 4'b0101, 32'h1FAF_F010, 32'h0102_0304);
        checkOutput("num_byte_write", num_out, 32'h0002_0004);
        applyStimulus(0, 0, 1, 4'h0, 32'h1FAF_F000, 0);
        checkOutput("led_read", data_sram_rdata, 32'h0000_00A5);

        // Timer write overrides that cycle's increment.
        applyStimulus(0, 0, 1, 4'hF, 32'h1FAF_E000, 32'h0000_1000);
        applyStimulus(0, 0, 1, 4'h0, 32'h1FAF_E000, 0);
        checkOutput("timer_override", data_sram_rdata, 32'h0000_1000);
        applyStimulus(0, 0, 1, 4'h0, 32'h1FAF_E000, 0);
        checkOutput("timer_next", data_sram_rdata, 32'h0000_1001);

        // Address mirroring above the memory width.
        applyStimulus(0, 0, 1, 4'hF, 32'h0001_0004, 32'hCAFE_F00D);
        applyStimulus(0, 0, 1, 4'h0, 32'h0000_0004, 0);
        checkOutput("mirror_read", data_sram_rdata, 32'hCAFE_F00D);

        // Asynchronous reset between edges, memory retained afterwards.
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_rst_data", data_sram_rdata, 32'h0);
        checkOutput("async_rst_inst", inst_sram_rdata, 32'h0);
        checkOutput("async_rst_led", {16'h0, led_out}, 32'h0000_FFFF);
        checkOutput("async_rst_num", num_out, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1, 32'h0000_0100, 1, 4'h0, 32'h0000_0004, 0);
        checkOutput("retained_data", data_sram_rdata, 32'hCAFE_F00D);
        checkOutput("retained_inst", inst_sram_rdata, 32'hDEAD_55EF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
